// File: rtl/regfile_pkg.sv
// Shared types and limits for the byte-enabled multi-read register file with array clear.
package regfile_pkg;

  localparam int unsigned N_READ_MAX = 4;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_e;

endpackage

// File: rtl/register_file_nr_1w_clr_if.sv
// Bus bundle for register_file_nr_1w_clr: read ports, write port, clear control, array view.
interface register_file_nr_1w_clr_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned N_READ     = 2
);
  localparam int unsigned N_WORDS = 2 ** ADDR_WIDTH;

  logic [N_READ-1:0]                   ReadEnable;
  logic [N_READ-1:0][ADDR_WIDTH-1:0]   ReadAddr;
  logic [N_READ-1:0][DATA_WIDTH-1:0]   ReadData;
  logic                                WriteEnable;
  logic [ADDR_WIDTH-1:0]               WriteAddr;
  logic [DATA_WIDTH-1:0]               WriteData;
  logic [DATA_WIDTH/8-1:0]             WriteBE;
  logic                                ClearReq;
  logic                                ClearBusy;
  logic [N_WORDS-1:0][DATA_WIDTH-1:0]  MemContent;

  modport master (
    output ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteData, WriteBE, ClearReq,
    input  ReadData, ClearBusy, MemContent
  );

  modport slave (
    input  ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteData, WriteBE, ClearReq,
    output ReadData, ClearBusy, MemContent
  );

endinterface

// File: rtl/regfile_be_merge.sv
// Byte-masked merge of a new word over an old word; feeds both the array write and the read bypass.
module regfile_be_merge #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0]   i_old,
  input  logic [DATA_WIDTH-1:0]   i_new,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  output logic [DATA_WIDTH-1:0]   o_merged
);

  always_comb begin
    o_merged = i_old;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (i_be[b]) o_merged[8*b +: 8] = i_new[8*b +: 8];
    end
  end

endmodule

// File: rtl/register_file_nr_1w_clr.sv
// Register file, N_READ registered read ports, one byte-enabled write port, sweeping clear.
// Define REGFILE_RW_BYPASS_EN to forward a same-cycle write to a read of the same address.
module register_file_nr_1w_clr
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned N_READ     = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  register_file_nr_1w_clr_if.slave bus
);

  localparam int unsigned N_WORDS = 2 ** ADDR_WIDTH;

  if (N_READ < 1 || N_READ > N_READ_MAX) begin : g_bad_n_read
    $error("register_file_nr_1w_clr: N_READ out of range");
  end

  logic [N_WORDS-1:0][DATA_WIDTH-1:0] r_mem;
  logic [N_READ-1:0][DATA_WIDTH-1:0]  r_rdata;
  clr_state_e                         r_state;
  logic [ADDR_WIDTH-1:0]              r_sweep_addr;
  logic [DATA_WIDTH-1:0]              w_wr_merged;
  logic                               w_wr_commit;

  regfile_be_merge #(.DATA_WIDTH(DATA_WIDTH)) u_be_merge (
    .i_old    (r_mem[bus.WriteAddr]),
    .i_new    (bus.WriteData),
    .i_be     (bus.WriteBE),
    .o_merged (w_wr_merged)
  );

  // Writes are dropped while the sweep owns the array.
  assign w_wr_commit = bus.WriteEnable && (r_state == CLR_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem        <= '0;
      r_rdata      <= '0;
      r_state      <= CLR_IDLE;
      r_sweep_addr <= '0;
    end else begin
      for (int p = 0; p < N_READ; p++) begin
        if (bus.ReadEnable[p]) begin
`ifdef REGFILE_RW_BYPASS_EN
          if (w_wr_commit && (bus.ReadAddr[p] == bus.WriteAddr))
            r_rdata[p] <= w_wr_merged;
          else
            r_rdata[p] <= r_mem[bus.ReadAddr[p]];
`else
          r_rdata[p] <= r_mem[bus.ReadAddr[p]];
`endif
        end
      end

      case (r_state)
        CLR_IDLE: begin
          if (bus.ClearReq) begin
            r_state      <= CLR_SWEEP;
            r_sweep_addr <= '0;
          end
        end
        CLR_SWEEP: begin
          r_mem[r_sweep_addr] <= '0;
          r_sweep_addr        <= r_sweep_addr + 1'b1;
          if (r_sweep_addr == ADDR_WIDTH'(N_WORDS - 1)) r_state <= CLR_IDLE;
        end
        default: r_state <= CLR_IDLE;
      endcase

      if (w_wr_commit) r_mem[bus.WriteAddr] <= w_wr_merged;
    end
  end

  assign bus.ReadData   = r_rdata;
  assign bus.ClearBusy  = (r_state == CLR_SWEEP);
  assign bus.MemContent = r_mem;

endmodule

// File: tb/tb_register_file_nr_1w_clr.sv
// Scoreboard bench for register_file_nr_1w_clr; honours REGFILE_RW_BYPASS_EN when defined.
module tb_register_file_nr_1w_clr;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 2;
  localparam int NW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  register_file_nr_1w_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR)) bus ();

  register_file_nr_1w_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] m_mem [NW];
  logic [DW-1:0] m_rd  [NR];
  logic          m_busy = 1'b0;
  logic [AW-1:0] m_ptr  = '0;

  typedef struct {
    int            port;
    logic [DW-1:0] exp;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [DW/8-1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int b = 0; b < DW / 8; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic idle();
    bus.ReadEnable  = '0;
    bus.ReadAddr    = '0;
    bus.WriteEnable = 1'b0;
    bus.WriteAddr   = '0;
    bus.WriteData   = '0;
    bus.WriteBE     = '0;
    bus.ClearReq    = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
    bus.WriteEnable = 1'b1;
    bus.WriteAddr   = a;
    bus.WriteData   = d;
    bus.WriteBE     = be;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    bus.ReadEnable[p] = 1'b1;
    bus.ReadAddr[p]   = a;
  endtask

  // Model the edge with the currently driven inputs, clock it, then compare.
  task automatic cycle(input string tag);
    logic          wcommit;
    logic [DW-1:0] merged;
    exp_t          e;
    wcommit = rst_n && !m_busy && bus.WriteEnable;
    merged  = merge(m_mem[bus.WriteAddr], bus.WriteData, bus.WriteBE);
    for (int p = 0; p < NR; p++) begin
      if (!rst_n) m_rd[p] = '0;
      else if (bus.ReadEnable[p]) begin
`ifdef REGFILE_RW_BYPASS_EN
        if (wcommit && bus.ReadAddr[p] == bus.WriteAddr) m_rd[p] = merged;
        else m_rd[p] = m_mem[bus.ReadAddr[p]];
`else
        m_rd[p] = m_mem[bus.ReadAddr[p]];
`endif
      end
      sb.push_back('{p, m_rd[p]});
    end
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) m_mem[i] = '0;
      m_busy = 1'b0;
      m_ptr  = '0;
    end else begin
      if (m_busy) begin
        m_mem[m_ptr] = '0;
        if (m_ptr == AW'(NW - 1)) m_busy = 1'b0;
        m_ptr = m_ptr + 1'b1;
      end else if (bus.ClearReq) begin
        m_busy = 1'b1;
        m_ptr  = '0;
      end
      if (wcommit) m_mem[bus.WriteAddr] = merged;
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s rd%0d", tag, e.port), bus.ReadData[e.port], e.exp);
    end
    check({tag, " busy"}, DW'(bus.ClearBusy), DW'(m_busy));
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < NW; i++) check($sformatf("%s mem%0d", tag, i), bus.MemContent[i], m_mem[i]);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < NW; i++) check($sformatf("%s zero%0d", tag, i), bus.MemContent[i], '0);
  endtask

  task automatic fill_all(input string tag);
    for (int i = 0; i < NW; i++) begin
      idle();
      wr(AW'(i), {$urandom, $urandom} | 64'h1, '1);
      if ($urandom_range(0, 1) == 1) rd(0, AW'($urandom_range(0, NW - 1)));
      if ($urandom_range(0, 1) == 1) rd(1, AW'($urandom_range(0, NW - 1)));
      cycle(tag);
    end
    idle();
  endtask

  // Runs until ClearBusy falls; writes and a stray ClearReq are thrown at the busy array.
  task automatic run_sweep(input string tag, output int busy_cnt);
    busy_cnt = bus.ClearBusy ? 1 : 0;
    for (int k = 0; k < 100 && bus.ClearBusy; k++) begin
      idle();
      wr(AW'($urandom_range(0, NW - 1)), '1, '1);
      bus.ClearReq = (k == 5);
      rd(0, AW'($urandom_range(0, NW - 1)));
      if ($urandom_range(0, 1) == 1) rd(1, AW'($urandom_range(0, NW - 1)));
      cycle(tag);
      if (bus.ClearBusy) busy_cnt++;
    end
    idle();
  endtask

  int busy_cnt;

  initial begin
    idle();
    rst_n = 1'b0;
    cycle("rst");
    cycle("rst");
    check_zero("rst");
    rst_n = 1'b1;

    idle(); wr(3, 64'h1122334455667788, 8'hFF); cycle("wr3");
    idle(); rd(0, 3);                           cycle("rd3");
    check("full_write", bus.ReadData[0], 64'h1122334455667788);

    idle(); wr(3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F); cycle("wr3be");
    idle(); rd(0, 3);                              cycle("rd3be");
    check("be_low_half", bus.ReadData[0], 64'h11223344FFFFFFFF);

    idle(); wr(3, 64'h0, 8'h00); cycle("wr3none");
    idle(); rd(1, 3);            cycle("rd3none");
    check("be_zero_noop", bus.ReadData[1], 64'h11223344FFFFFFFF);

    idle(); rd(0, 9); cycle("hold_setup");
    idle(); bus.ReadAddr[0] = 3; cycle("hold");

    idle(); wr(5, 64'h0123456789ABCDEF, 8'hFF); cycle("wr5old");
    idle(); wr(5, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF); rd(1, 5); rd(0, 5); cycle("rw5");
`ifdef REGFILE_RW_BYPASS_EN
    check("rw_same_cycle", bus.ReadData[1], 64'hAAAA_AAAA_AAAA_AAAA);
`else
    check("rw_same_cycle", bus.ReadData[1], 64'h0123456789ABCDEF);
`endif
    idle(); rd(1, 5); cycle("rd5new");
    check("rw_next_read", bus.ReadData[1], 64'hAAAA_AAAA_AAAA_AAAA);

    fill_all("fill");
    check_mem("fill");
    idle(); bus.ClearReq = 1'b1; cycle("clr_req");
    run_sweep("sweep", busy_cnt);
    check("sweep_len", DW'(busy_cnt), DW'(32));
    check_zero("swept");

    idle(); wr(9, 64'hDEAD_BEEF_0000_1234, 8'hFF); bus.ClearReq = 1'b1; cycle("wr_clr");
    check("wr_with_clr", bus.MemContent[9], 64'hDEAD_BEEF_0000_1234);
    run_sweep("sweep2", busy_cnt);
    check("sweep2_len", DW'(busy_cnt), DW'(32));
    check("wr_with_clr_zeroed", bus.MemContent[9], '0);

    fill_all("fill2");
    idle(); bus.ClearReq = 1'b1; cycle("clr_req3");
    for (int k = 0; k < 9; k++) begin idle(); rd(0, AW'(k)); cycle("part"); end
    check_mem("partial");
    idle(); rst_n = 1'b0; cycle("rst_mid");
    check("rst_mid_busy", DW'(bus.ClearBusy), '0);
    check_zero("rst_mid");
    rst_n = 1'b1;
    idle(); cycle("post_rst");
    check("post_rst_idle", DW'(bus.ClearBusy), '0);

    fill_all("fill3");
    idle(); bus.ClearReq = 1'b1; cycle("clr_req4");
    run_sweep("sweep4", busy_cnt);
    check("fresh_sweep_len", DW'(busy_cnt), DW'(32));
    check_zero("swept4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/register_file_nr_1w_clr.md
REGISTER_FILE_NR_1W_CLR -- requirements
Module: register_file_nr_1w_clr

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, word address width; depth N_WORDS = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, word width, multiple of 8.
REQ-003 SHALL have parameter N_READ, default 2, number of independent read ports, range 1..4.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 ReadEnable  input  N_READ  per-port read strobe.
REQ-007 ReadAddr  input  N_READ x ADDR_WIDTH  per-port read address.
REQ-008 ReadData  output  N_READ x DATA_WIDTH  per-port registered read data.
REQ-009 WriteEnable  input  1  write strobe.
REQ-010 WriteAddr  input  ADDR_WIDTH  write address.
REQ-011 WriteData  input  DATA_WIDTH  write data.
REQ-012 WriteBE  input  DATA_WIDTH/8  byte enables, bit i covers bits [8i+7:8i].
REQ-013 ClearReq  input  1  single-cycle pulse requesting a full-array clear.
REQ-014 ClearBusy  output  1  high while the clear sweep is in progress.
REQ-015 MemContent  output  N_WORDS x DATA_WIDTH  live array contents, no added latency.

Function
REQ-016 Read latency SHALL be 1 cycle: when ReadEnable[p] is high at edge k, ReadData[p] SHALL show word ReadAddr[p] from edge k+1.
REQ-017 When ReadEnable[p] is low, ReadData[p] SHALL hold its previous value.
REQ-018 A write SHALL update only the bytes with WriteBE set; unselected bytes keep their value; WriteBE all-zero is a no-op.
REQ-019 The clear FSM SHALL have two states: IDLE and SWEEP.
REQ-020 IDLE -> SWEEP SHALL occur on ClearReq high; the sweep counter loads 0.
REQ-021 In SWEEP, one word per cycle SHALL be zeroed at counter address, counter incrementing; after address N_WORDS-1 the FSM SHALL return to IDLE.
REQ-022 A sweep SHALL take exactly N_WORDS cycles; ClearBusy SHALL be high during SWEEP and low in IDLE.
REQ-023 During SWEEP, WriteEnable SHALL be ignored (write dropped); callers must check ClearBusy.
REQ-024 During SWEEP, ClearReq SHALL be ignored (no restart).
REQ-025 ClearReq and WriteEnable in the same IDLE cycle: the write SHALL commit, and the sweep SHALL start next cycle and zero it.
REQ-026 Reads SHALL remain serviced during SWEEP and return current (partially cleared) contents.
REQ-027 Multiple read ports addressing the same word SHALL all return identical data.

Reset
REQ-028 With rst_n low at a clock edge, all words, every ReadData and the sweep counter SHALL become 0, FSM SHALL enter IDLE, and ClearBusy SHALL be 0.
REQ-029 Reset asserted mid-sweep SHALL abort the sweep; there SHALL be no resume.

Configuration
REQ-030 Macro REGFILE_RW_BYPASS_EN defined: a read of the address being written in the same cycle SHALL return the byte-merged new word.
REQ-031 Macro REGFILE_RW_BYPASS_EN undefined: that read SHALL return the pre-write word, and the new data SHALL be visible from the following read.

Structure
REQ-032 A package regfile_pkg SHALL hold the FSM state enum (CLR_IDLE, CLR_SWEEP) and the N_READ upper-bound constant.
REQ-033 Byte-masked merge logic SHALL be a sub-module regfile_be_merge, shared by the write path and the bypass path.

Verification
REQ-034 Write 0x1122334455667788 to address 3, WriteBE=0xFF; next cycle read port 0 addr 3 -> ReadData[0]=0x1122334455667788 one cycle later.
REQ-035 Over the word above, write 0xFFFFFFFFFFFFFFFF with WriteBE=0x0F -> read returns 0x11223344FFFFFFFF.
REQ-036 Pulse ClearReq with all words nonzero -> ClearBusy high for exactly 32 cycles; afterwards all MemContent=0; writes issued during busy have no effect.
REQ-037 Same-cycle write addr 5 data 0xAA.., BE=0xFF, and port 1 read addr 5 -> with REGFILE_RW_BYPASS_EN, ReadData[1]=0xAA..; without it, the old value.
REQ-038 Assert rst_n low at sweep cycle 10 -> next edge ClearBusy=0, all words 0, FSM IDLE; then a fresh ClearReq runs a full 32-cycle sweep.
